decimal_request_arbiter: RTL and testbench
==========================================

// Module: decimal_request_arbiter
// PURPOSE
//  Shares one resource between 10 requesters, numbered 0-9 like the decimal
//  priority encoder.
//  Registers a one-hot grant plus a 4-bit binary index of the winner.
//  Holds the grant until the holder finishes, drops its request, or exceeds a hold limit.
//  Selects fixed priority (highest index wins) or round-robin.
//  Sits between the requesting units and the shared-resource mux, which gnt_idx steers.
// PARAMETERS
//  N_REQ    10  number of requesters (fixed at 10 for this block)
//  IDX_W    4   width of gnt_idx
//  MAX_HOLD 15  max consecutive cycles one grant may be held (>=1)
//  RR_EN    1   1 = round-robin priority rotation, 0 = fixed, highest index wins
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous reset, active low
//  req        in   10     request vector, bit i = requester i
//  done       in   1      current holder releases the resource (ignored unless GRANT)
//  gnt        out  10     one-hot grant, registered
//  gnt_valid  out  1      high when gnt is non-zero
//  gnt_idx    out  4      binary index of granted requester (0 when !gnt_valid)
//  timeout    out  1      1-cycle pulse: grant force-released at MAX_HOLD
// BEHAVIOUR
//  - Clocking and reset:
//    - One clock domain.
//    - Reset is synchronous and active-low.
//    - rst_n=0 at an edge forces: state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0,
//      timeout=0, hold_cnt=0, rr_ptr=0.
//    - Reset overrides all else, including mid-grant.
//  - FSM states: IDLE, GRANT.
//  - IDLE:
//    - If req!=0 at an edge, the winner is loaded into gnt/gnt_idx, gnt_valid=1,
//      hold_cnt=0, and the FSM moves to GRANT.
//    - Latency is one cycle from sampled req to visible grant.
//    - If req==0, the FSM stays in IDLE with all outputs 0.
//  - GRANT: hold_cnt increments every cycle. Release at the edge where any of:
//    (a) done=1;
//    (b) req[gnt_idx]=0 (holder withdrew);
//    (c) hold_cnt==MAX_HOLD-1, i.e. the grant has been visible MAX_HOLD cycles.
//  - On release:
//    - Next state is IDLE, gnt=0, gnt_valid=0, gnt_idx=0.
//    - timeout=1 for that one cycle only if (c) alone caused the release.
//    - done or req-drop in the same cycle as (c) suppresses timeout.
//    - There is always >=1 dead cycle (gnt=0) between consecutive grants.
//  - Winner selection (combinational, evaluated in IDLE only):
//    - RR_EN=0: highest set index of req wins.
//    - RR_EN=1: search order is rr_ptr-1, rr_ptr-2, ..., 0, 9, 8, ..., rr_ptr
//      (mod 10). The first set bit wins.
//    - rr_ptr is updated to the winner index when the grant is issued.
//    - rr_ptr=0 after reset, so the first arbitration equals fixed priority.
//    - A lone requester is always re-granted, even if it was the last holder.
//  - Widths: hold_cnt is $clog2(MAX_HOLD+1) bits and never wraps (cleared on
//    each grant). rr_ptr is 4 bits, range 0-9 only.
//  - gnt is always one-hot or zero. gnt_idx always equals the position of the set bit.
//  - req changes from non-holders during GRANT have no effect until the next IDLE.
// STRUCTURE
//  - Package arb_pkg holds:
//    - localparams N_REQ=10 and IDX_W=4;
//    - typedef enum {IDLE, GRANT} arb_state_t;
//    - function idx_to_onehot.
//  - Sub-module arb_pri_select:
//    - purely combinational;
//    - inputs req[9:0], rr_ptr[3:0], rr_en;
//    - outputs win_idx[3:0], win_any.
//  - Top level holds the FSM, hold counter, rr_ptr and the output registers.
// TESTING
//  1. Reset:
//     - Stimulus: rst_n=0 for 2 cycles with req=10'h3FF, done=1.
//     - Required: gnt=0, gnt_valid=0, gnt_idx=0, timeout=0. First grant after
//       release of reset is idx 9.
//  2. Fixed priority (RR_EN=0):
//     - Stimulus: req=10'b0000100100.
//     - Required: next cycle gnt=10'b0000100000, gnt_idx=5.
//     - Then done=1 for 1 cycle: following cycle gnt=0; the cycle after that
//       grants idx 5 again.
//  3. Round-robin (RR_EN=1):
//     - Stimulus: req=10'h3FF held; done pulsed in every GRANT cycle.
//     - Required: grant index sequence 9,8,7,...,0,9, with one dead cycle between grants.
//  4. Timeout (MAX_HOLD=4):
//     - Stimulus: req=10'b0000001000 held, done=0.
//     - Required: gnt_idx=3 for exactly 4 cycles; timeout=1 in the single cycle
//       gnt drops; idx 3 re-granted next.
//     - Repeat with done=1 in the 4th cycle: timeout stays 0.
//  5. Holder withdraw and mid-grant reset:
//     - Stimulus: grant idx 7, then clear req[7].
//     - Required: gnt=0 next cycle, timeout=0.
//     - Stimulus: re-grant, then assert rst_n=0 mid-GRANT.
//     - Required: all outputs 0 at that edge; rr_ptr back to 0.
//  6. Isolation:
//     - Stimulus: during grant to idx 2, toggle req[9], and pulse done while in IDLE.
//     - Required: gnt unchanged during the grant; done in IDLE causes no state
//       change and no timeout.

Source files
------------

// File: rtl/decimal_request_arbiter_pkg.sv
// Shared definitions for the 10-requester decimal arbiter.
//   N_REQ / IDX_W : requester count and grant-index width (fixed for this block)
//   arb_state_t   : arbiter FSM states
//   idx_to_onehot : binary requester index -> one-hot grant vector
package arb_pkg;

  localparam int unsigned N_REQ = 10;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  // Indices 10-15 cannot occur in the arbiter; they map to all-zero.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/decimal_request_arbiter_pri_select.sv
// Combinational winner selection for the decimal request arbiter.
//   req     in  10  request vector
//   rr_ptr  in  4   index of the last granted requester (0-9)
//   rr_en   in  1   1 = rotate priority from rr_ptr, 0 = highest index wins
//   win_idx out 4   index of the selected requester (0 when none)
//   win_any out 1   at least one request is set
module arb_pri_select
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  input  logic             rr_en,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_any
);

  int unsigned      base;
  logic [IDX_W-1:0] pos;

  // Search order is base-1, base-2, ... wrapping mod N_REQ, ending at base.
  // Fixed priority is the same search with base forced to 0 (9 down to 0).
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    pos     = '0;
    base    = rr_en ? 32'(rr_ptr) : 32'd0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      pos = IDX_W'((base + N_REQ - k) % N_REQ);
      if (!win_any && req[pos]) begin
        win_any = 1'b1;
        win_idx = pos;
      end
    end
  end

endmodule

// File: rtl/decimal_request_arbiter.sv
// Arbitrates one shared resource among 10 requesters (0-9).
// Grant is registered one cycle after the request is sampled and held until
// done, the holder's request drops, or MAX_HOLD visible cycles elapse. Every
// release is followed by at least one idle cycle with gnt = 0.
//   clk       in  1   rising-edge clock
//   rst_n     in  1   synchronous reset, active low
//   req       in  10  request vector
//   done      in  1   holder releases the resource (only acted on in GRANT)
//   gnt       out 10  one-hot grant, registered
//   gnt_valid out 1   gnt is non-zero
//   gnt_idx   out 4   binary index of the holder (0 when idle)
//   timeout   out 1   one-cycle pulse when a grant is force-released at MAX_HOLD
module decimal_request_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned RR_EN    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             timeout
);

  localparam int unsigned      HCW       = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0]   HOLD_LAST = HCW'(MAX_HOLD - 1);
  localparam logic             RR_ON     = (RR_EN != 0);

  arb_state_t       state, state_nxt;
  logic [HCW-1:0]   hold_cnt, hold_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic             valid_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             timeout_nxt;

  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             holder_drop;
  logic             hold_expired;

  arb_pri_select u_sel (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .rr_en   (RR_ON),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  assign holder_drop  = ((req & gnt) == '0);
  assign hold_expired = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= valid_nxt;
      gnt_idx   <= idx_nxt;
      timeout   <= timeout_nxt;
      hold_cnt  <= hold_nxt;
      rr_ptr    <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    valid_nxt   = gnt_valid;
    idx_nxt     = gnt_idx;
    timeout_nxt = 1'b0;
    hold_nxt    = hold_cnt;
    rr_nxt      = rr_ptr;

    unique case (state)
      IDLE: begin
        if (win_any) begin
          state_nxt = GRANT;
          gnt_nxt   = idx_to_onehot(win_idx);
          valid_nxt = 1'b1;
          idx_nxt   = win_idx;
          hold_nxt  = '0;
          rr_nxt    = win_idx;
        end else begin
          gnt_nxt   = '0;
          valid_nxt = 1'b0;
          idx_nxt   = '0;
        end
      end
      GRANT: begin
        if (done || holder_drop || hold_expired) begin
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          valid_nxt   = 1'b0;
          idx_nxt     = '0;
          // A voluntary release in the same cycle masks the forced one.
          timeout_nxt = hold_expired && !done && !holder_drop;
        end else begin
          hold_nxt = hold_cnt + HCW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_decimal_request_arbiter.sv
// Directed bench for decimal_request_arbiter.
// Instance a: fixed priority, MAX_HOLD=4. Instance b: round-robin, MAX_HOLD=4.
module tb_decimal_request_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] a_req, b_req;
  logic       a_done, b_done;
  logic [9:0] a_gnt, b_gnt;
  logic       a_valid, b_valid;
  logic [3:0] a_idx, b_idx;
  logic       a_to, b_to;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decimal_request_arbiter #(.MAX_HOLD(4), .RR_EN(0)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (a_req),
    .done      (a_done),
    .gnt       (a_gnt),
    .gnt_valid (a_valid),
    .gnt_idx   (a_idx),
    .timeout   (a_to)
  );

  decimal_request_arbiter #(.MAX_HOLD(4), .RR_EN(1)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (b_req),
    .done      (b_done),
    .gnt       (b_gnt),
    .gnt_valid (b_valid),
    .gnt_idx   (b_idx),
    .timeout   (b_to)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_idle(input string tag);
    check({tag, " a_gnt"}, 32'(a_gnt), 32'h0);
    check({tag, " a_valid"}, 32'(a_valid), 32'h0);
    check({tag, " a_idx"}, 32'(a_idx), 32'h0);
  endtask

  task automatic check_a_grant(input string tag, input int idx);
    check({tag, " a_gnt"}, 32'(a_gnt), 32'h1 << idx);
    check({tag, " a_valid"}, 32'(a_valid), 32'h1);
    check({tag, " a_idx"}, 32'(a_idx), 32'(idx));
  endtask

  task automatic check_b_grant(input string tag, input int idx);
    check({tag, " b_gnt"}, 32'(b_gnt), 32'h1 << idx);
    check({tag, " b_idx"}, 32'(b_idx), 32'(idx));
  endtask

  initial begin
    int exp_idx;
    rst_n  = 1'b0;
    a_req  = '0;
    b_req  = '0;
    a_done = 1'b0;
    b_done = 1'b0;

    // 1. Reset with every request and done asserted
    a_req = 10'h3FF; b_req = 10'h3FF; a_done = 1'b1; b_done = 1'b1;
    tick(); tick();
    check_a_idle("rst");
    check("rst a_to", 32'(a_to), 32'h0);
    check("rst b_gnt", 32'(b_gnt), 32'h0);
    check("rst b_valid", 32'(b_valid), 32'h0);
    check("rst b_to", 32'(b_to), 32'h0);
    rst_n = 1'b1; a_done = 1'b0; b_done = 1'b0;
    tick();
    check_a_grant("rst first", 9);
    check_b_grant("rst first", 9);
    a_req = '0; b_req = '0;
    tick();
    check_a_idle("rst drop");
    check("rst drop a_to", 32'(a_to), 32'h0);
    tick();

    // 2. Fixed priority: highest set index wins, dead cycle after done
    a_req = 10'b0000100100;
    tick();
    check_a_grant("fix", 5);
    a_done = 1'b1;
    tick();
    check_a_idle("fix done");
    check("fix done a_to", 32'(a_to), 32'h0);
    a_done = 1'b0;
    tick();
    check_a_grant("fix regrant", 5);
    a_req = '0;
    tick(); tick();

    // 3. Round-robin from a fresh reset: 9,8,...,0,9
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    b_req = 10'h3FF; b_done = 1'b1;
    tick();
    check_b_grant("rr first", 9);
    for (int i = 0; i < 10; i++) begin
      exp_idx = (i < 9) ? 8 - i : 9;
      tick();
      check($sformatf("rr dead%0d b_gnt", i), 32'(b_gnt), 32'h0);
      tick();
      check_b_grant($sformatf("rr seq%0d", i), exp_idx);
    end
    b_req = '0; b_done = 1'b0;
    tick(); tick();

    // 4. Timeout after 4 visible cycles, then done in the 4th cycle masks it
    a_req = 10'b0000001000;
    tick();
    for (int k = 0; k < 4; k++) begin
      check_a_grant($sformatf("to hold%0d", k), 3);
      check($sformatf("to hold%0d a_to", k), 32'(a_to), 32'h0);
      tick();
    end
    check_a_idle("to rel");
    check("to rel a_to", 32'(a_to), 32'h1);
    tick();
    check_a_grant("to regrant", 3);
    check("to regrant a_to", 32'(a_to), 32'h0);
    tick(); tick(); tick();
    check_a_grant("to c4", 3);
    a_done = 1'b1;
    tick();
    check_a_idle("to done rel");
    check("to done rel a_to", 32'(a_to), 32'h0);
    a_done = 1'b0; a_req = '0;
    tick();
    check_a_idle("to after");
    check("to after a_to", 32'(a_to), 32'h0);

    // 5. Holder withdraws, then reset mid-grant restores rr_ptr
    b_req = 10'b0010000000;
    tick();
    check_b_grant("wd", 7);
    b_req = '0;
    tick();
    check("wd rel b_gnt", 32'(b_gnt), 32'h0);
    check("wd rel b_to", 32'(b_to), 32'h0);
    b_req = 10'b0010000000;
    tick();
    check_b_grant("wd regrant", 7);
    b_req = 10'h3FF; rst_n = 1'b0;
    tick();
    check("mrst b_gnt", 32'(b_gnt), 32'h0);
    check("mrst b_valid", 32'(b_valid), 32'h0);
    check("mrst b_idx", 32'(b_idx), 32'h0);
    check("mrst b_to", 32'(b_to), 32'h0);
    rst_n = 1'b1;
    tick();
    check_b_grant("mrst ptr", 9);
    b_req = '0;
    tick(); tick();

    // 6. Isolation: non-holder toggles during a grant, done pulsed in IDLE
    a_req = 10'b0000000100;
    tick();
    check_a_grant("iso", 2);
    a_req = 10'b1000000100;
    tick();
    check_a_grant("iso r9on", 2);
    a_req = 10'b0000000100;
    tick();
    check_a_grant("iso r9off", 2);
    a_req = 10'b1000000100;
    tick();
    check_a_grant("iso r9on2", 2);
    a_req = '0;
    tick();
    check_a_idle("iso rel");
    check("iso rel a_to", 32'(a_to), 32'h0);
    a_done = 1'b1;
    tick();
    check_a_idle("iso idle done");
    check("iso idle done a_to", 32'(a_to), 32'h0);
    a_done = 1'b0;
    tick();
    check_a_idle("iso idle after");
    check("iso idle after a_to", 32'(a_to), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
